// File: rtl/fix_seq_pkg.sv
// Shared types and helpers for the FIX sequence-number manager and its
// binary-to-ASCII converter.
package fix_seq_pkg;

    typedef enum logic [1:0] {
        CHK_OK  = 2'd0,
        CHK_GAP = 2'd1,
        CHK_LOW = 2'd2,
        CHK_DUP = 2'd3
    } chk_status_t;

    typedef enum logic [1:0] {
        OUT_IDLE = 2'd0,
        OUT_CONV = 2'd1,
        OUT_HOLD = 2'd2
    } out_state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;

    // True when DIGITS decimal digits can hold the largest SEQ_WIDTH-bit value.
    function automatic bit digits_fit(input int digits, input int seq_width);
        longint unsigned max_val;
        longint unsigned pow10;
        max_val = (seq_width >= 63) ? 64'h7FFF_FFFF_FFFF_FFFF
                                    : ((64'd1 << seq_width) - 64'd1);
        pow10 = 64'd1;
        for (int i = 0; i < digits; i++) begin
            if (pow10 <= max_val)
                pow10 = pow10 * 64'd10;
        end
        return pow10 > max_val;
    endfunction

endpackage

// File: rtl/fix_seq_manager_bin2ascii.sv
// Iterative double-dabble converter: one shift-add-3 step per cycle, then
// registers ASCII digits with leading-zero suppression and the digit count.
module fix_bin2ascii
    import fix_seq_pkg::*;
#(
    parameter int SEQ_WIDTH  = 32,
    parameter int DIGITS     = 10,
    parameter int SIZE_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [SEQ_WIDTH-1:0]  bin,
    output logic                  done,
    output logic [8*DIGITS-1:0]   ascii,
    output logic [SIZE_WIDTH-1:0] size
);

    localparam int CW = $clog2(SEQ_WIDTH + 1);

    logic [SEQ_WIDTH-1:0]  bin_q, bin_next;
    logic [4*DIGITS-1:0]   bcd_q, bcd_adj, bcd_next;
    logic [CW-1:0]         cnt_q;
    logic                  busy_q;
    logic [8*DIGITS-1:0]   ascii_next;
    logic [SIZE_WIDTH-1:0] size_next;
    logic                  found;

    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5)
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
        end
        bcd_next = (bcd_adj << 1) | {{(4*DIGITS-1){1'b0}}, bin_q[SEQ_WIDTH-1]};
        bin_next = bin_q << 1;
    end

    // Rendered from the final step's BCD so the result registers on the last edge.
    always_comb begin
        found      = 1'b0;
        size_next  = SIZE_WIDTH'(1);
        ascii_next = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (!found && bcd_next[4*k +: 4] != 4'd0) begin
                found     = 1'b1;
                size_next = SIZE_WIDTH'(k + 1);
            end
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (k < int'(size_next))
                ascii_next[8*k +: 8] = ASCII_ZERO | {4'd0, bcd_next[4*k +: 4]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            ascii  <= '0;
            size   <= '0;
        end else if (start) begin
            bin_q  <= bin;
            bcd_q  <= '0;
            cnt_q  <= CW'(SEQ_WIDTH);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            bin_q <= bin_next;
            bcd_q <= bcd_next;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_q <= 1'b0;
                ascii  <= ascii_next;
                size   <= size_next;
            end
        end
    end

    assign done = busy_q && (cnt_q == CW'(1));

endmodule

// File: rtl/fix_seq_manager.sv
// Per-host FIX sequence-number manager: inbound MsgSeqNum checking against an
// expected table, and outbound allocation rendered to ASCII digits.
`ifndef HOST_ADDR_WIDTH
`define HOST_ADDR_WIDTH 3
`endif

module fix_seq_manager
    import fix_seq_pkg::*;
#(
    parameter int HOST_ADDR_WIDTH = `HOST_ADDR_WIDTH,
    parameter int SEQ_WIDTH       = 32,
    parameter int DIGITS          = 10,
    parameter int SIZE_WIDTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [HOST_ADDR_WIDTH-1:0] in_host_i,
    input  logic [SEQ_WIDTH-1:0]       in_seq_i,
    input  logic                       in_poss_dup_i,
    output logic                       chk_valid_o,
    output logic [1:0]                 chk_status_o,
    output logic [SEQ_WIDTH-1:0]       chk_expected_o,
    input  logic                       set_valid_i,
    input  logic                       set_dir_i,
    input  logic [HOST_ADDR_WIDTH-1:0] set_host_i,
    input  logic [SEQ_WIDTH-1:0]       set_value_i,
    input  logic                       out_req_i,
    input  logic [HOST_ADDR_WIDTH-1:0] out_host_i,
    output logic                       out_accept_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [SEQ_WIDTH-1:0]       out_seq_o,
    output logic [8*DIGITS-1:0]        out_ascii_o,
    output logic [SIZE_WIDTH-1:0]      out_size_o,
    output logic                       seq_wrap_o
);

    localparam int DEPTH = 1 << HOST_ADDR_WIDTH;

    generate
        if (!digits_fit(DIGITS, SEQ_WIDTH)) begin : g_capacity_check
            $error("fix_seq_manager: DIGITS cannot represent every SEQ_WIDTH value");
        end
    endgenerate

    // Sequence numbers skip 0: the all-ones value wraps straight to 1.
    function automatic logic [SEQ_WIDTH-1:0] inc_seq(input logic [SEQ_WIDTH-1:0] v);
        return (&v) ? SEQ_WIDTH'(1) : v + SEQ_WIDTH'(1);
    endfunction

    logic [SEQ_WIDTH-1:0] in_tbl  [DEPTH];
    logic [SEQ_WIDTH-1:0] out_tbl [DEPTH];
    logic [DEPTH-1:0]     in_vld, out_vld;
    logic [SEQ_WIDTH-1:0] in_cur, out_cur;
    logic                 set_in, set_out, in_fire, in_write, conv_done;
    chk_status_t          in_status;
    out_state_t           state_q, state_d;

    assign in_cur  = in_vld[in_host_i]   ? in_tbl[in_host_i]   : SEQ_WIDTH'(1);
    assign out_cur = out_vld[out_host_i] ? out_tbl[out_host_i] : SEQ_WIDTH'(1);

    assign set_in     = set_valid_i && !set_dir_i;
    assign set_out    = set_valid_i && set_dir_i;
    assign in_ready_o = !(set_in && (set_host_i == in_host_i));
    assign in_fire    = in_valid_i && in_ready_o;

    always_comb begin
        in_status = CHK_OK;
        if (in_seq_i == in_cur)
            in_status = CHK_OK;
        else if (in_seq_i > in_cur)
            in_status = CHK_GAP;
        else if (in_poss_dup_i)
            in_status = CHK_DUP;
        else
            in_status = CHK_LOW;
    end

    assign in_write = in_fire && (in_status == CHK_OK);

    always_comb begin
        state_d      = state_q;
        out_accept_o = 1'b0;
        case (state_q)
            OUT_IDLE: begin
                out_accept_o = out_req_i && !(set_out && (set_host_i == out_host_i));
                if (out_accept_o)
                    state_d = OUT_CONV;
            end
            OUT_CONV: if (conv_done) state_d = OUT_HOLD;
            OUT_HOLD: if (out_ready_i) state_d = OUT_IDLE;
            default:  state_d = OUT_IDLE;
        endcase
    end

    assign out_valid_o = (state_q == OUT_HOLD);

    // Conflicting same-host requests are blocked, so these writes never collide.
    always_ff @(posedge clk) begin
        if (in_write)     in_tbl[in_host_i]    <= inc_seq(in_cur);
        if (set_in)       in_tbl[set_host_i]   <= set_value_i;
        if (out_accept_o) out_tbl[out_host_i]  <= inc_seq(out_cur);
        if (set_out)      out_tbl[set_host_i]  <= set_value_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_vld         <= '0;
            out_vld        <= '0;
            state_q        <= OUT_IDLE;
            chk_valid_o    <= 1'b0;
            chk_status_o   <= '0;
            chk_expected_o <= '0;
            out_seq_o      <= '0;
            seq_wrap_o     <= 1'b0;
        end else begin
            if (in_write)     in_vld[in_host_i]   <= 1'b1;
            if (set_in)       in_vld[set_host_i]  <= 1'b1;
            if (out_accept_o) out_vld[out_host_i] <= 1'b1;
            if (set_out)      out_vld[set_host_i] <= 1'b1;
            state_q     <= state_d;
            chk_valid_o <= in_fire;
            if (in_fire) begin
                chk_status_o   <= in_status;
                chk_expected_o <= in_cur;
            end
            if (out_accept_o)
                out_seq_o <= out_cur;
            seq_wrap_o <= (in_write && (&in_cur)) || (out_accept_o && (&out_cur));
        end
    end

    fix_bin2ascii #(
        .SEQ_WIDTH  (SEQ_WIDTH),
        .DIGITS     (DIGITS),
        .SIZE_WIDTH (SIZE_WIDTH)
    ) u_bin2ascii (
        .clk   (clk),
        .rst_n (rst_n),
        .start (out_accept_o),
        .bin   (out_cur),
        .done  (conv_done),
        .ascii (out_ascii_o),
        .size  (out_size_o)
    );

endmodule

// File: tb/tb_fix_seq_manager.sv
// Directed bench for fix_seq_manager: inbound classification, set conflicts,
// outbound allocation with ASCII rendering, wrap and mid-conversion reset.
module tb_fix_seq_manager;
    import fix_seq_pkg::*;

    localparam int HW = 3;
    localparam int SW = 32;
    localparam int DG = 10;
    localparam int ZW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid_i, in_ready_o, in_poss_dup_i;
    logic [HW-1:0] in_host_i;
    logic [SW-1:0] in_seq_i;
    logic          chk_valid_o;
    logic [1:0]    chk_status_o;
    logic [SW-1:0] chk_expected_o;
    logic          set_valid_i, set_dir_i;
    logic [HW-1:0] set_host_i;
    logic [SW-1:0] set_value_i;
    logic          out_req_i, out_accept_o, out_valid_o, out_ready_i;
    logic [HW-1:0] out_host_i;
    logic [SW-1:0] out_seq_o;
    logic [8*DG-1:0] out_ascii_o;
    logic [ZW-1:0] out_size_o;
    logic          seq_wrap_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fix_seq_manager #(
        .HOST_ADDR_WIDTH (HW),
        .SEQ_WIDTH       (SW),
        .DIGITS          (DG),
        .SIZE_WIDTH      (ZW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_host_i      (in_host_i),
        .in_seq_i       (in_seq_i),
        .in_poss_dup_i  (in_poss_dup_i),
        .chk_valid_o    (chk_valid_o),
        .chk_status_o   (chk_status_o),
        .chk_expected_o (chk_expected_o),
        .set_valid_i    (set_valid_i),
        .set_dir_i      (set_dir_i),
        .set_host_i     (set_host_i),
        .set_value_i    (set_value_i),
        .out_req_i      (out_req_i),
        .out_host_i     (out_host_i),
        .out_accept_o   (out_accept_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_seq_o      (out_seq_o),
        .out_ascii_o    (out_ascii_o),
        .out_size_o     (out_size_o),
        .seq_wrap_o     (seq_wrap_o)
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One inbound check, result sampled in the following cycle.
    task automatic applyStimulus(input logic [HW-1:0] host, input logic [SW-1:0] seq,
                                 input logic dup, input logic [1:0] exp_status,
                                 input logic [SW-1:0] exp_expected, input string tag);
        in_valid_i    = 1'b1;
        in_host_i     = host;
        in_seq_i      = seq;
        in_poss_dup_i = dup;
        tick();
        in_valid_i    = 1'b0;
        in_poss_dup_i = 1'b0;
        checkOutput({tag, ".valid"}, chk_valid_o, 1);
        checkOutput({tag, ".status"}, chk_status_o, exp_status);
        checkOutput({tag, ".expected"}, chk_expected_o, exp_expected);
    endtask

    task automatic setCounter(input logic dir, input logic [HW-1:0] host,
                              input logic [SW-1:0] value);
        set_valid_i = 1'b1;
        set_dir_i   = dir;
        set_host_i  = host;
        set_value_i = value;
        tick();
        set_valid_i = 1'b0;
    endtask

    task automatic requestOut(input logic [HW-1:0] host, input logic [SW-1:0] exp_seq,
                              input logic [8*DG-1:0] exp_ascii, input logic [ZW-1:0] exp_size,
                              input logic exp_wrap, input string tag);
        int lat;
        out_req_i  = 1'b1;
        out_host_i = host;
        #1;
        checkOutput({tag, ".accept"}, out_accept_o, 1);
        tick();
        out_req_i = 1'b0;
        lat = 1;
        checkOutput({tag, ".wrap"}, seq_wrap_o, exp_wrap);
        out_req_i = 1'b1;
        #1;
        checkOutput({tag, ".busy_accept"}, out_accept_o, 0);
        out_req_i = 1'b0;
        while (!out_valid_o && lat < 100) begin
            tick();
            lat++;
        end
        checkOutput({tag, ".latency"}, lat, SW + 1);
        checkOutput({tag, ".seq"}, out_seq_o, exp_seq);
        checkOutput({tag, ".ascii"}, out_ascii_o, exp_ascii);
        checkOutput({tag, ".size"}, out_size_o, exp_size);
        tick();
        checkOutput({tag, ".held_valid"}, out_valid_o, 1);
        checkOutput({tag, ".held_seq"}, out_seq_o, exp_seq);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        checkOutput({tag, ".released"}, out_valid_o, 0);
    endtask

    initial begin
        int seen;
        rst_n         = 1'b0;
        in_valid_i    = 1'b0;
        in_host_i     = '0;
        in_seq_i      = '0;
        in_poss_dup_i = 1'b0;
        set_valid_i   = 1'b0;
        set_dir_i     = 1'b0;
        set_host_i    = '0;
        set_value_i   = '0;
        out_req_i     = 1'b0;
        out_host_i    = '0;
        out_ready_i   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst.chk_valid", chk_valid_o, 0);
        checkOutput("rst.chk_status", chk_status_o, 0);
        checkOutput("rst.chk_expected", chk_expected_o, 0);
        checkOutput("rst.out_valid", out_valid_o, 0);
        checkOutput("rst.out_seq", out_seq_o, 0);
        checkOutput("rst.out_ascii", out_ascii_o, 0);
        checkOutput("rst.out_size", out_size_o, 0);
        checkOutput("rst.wrap", seq_wrap_o, 0);
        rst_n = 1'b1;
        tick();

        applyStimulus(3, 1, 0, CHK_OK, 1, "h3_first");
        applyStimulus(3, 1, 0, CHK_LOW, 2, "h3_repeat");
        tick();
        checkOutput("h3_idle.valid", chk_valid_o, 0);

        setCounter(0, 5, 10);
        applyStimulus(5, 14, 0, CHK_GAP, 10, "h5_gap");
        applyStimulus(5, 7, 1, CHK_DUP, 10, "h5_dup");
        applyStimulus(5, 7, 0, CHK_LOW, 10, "h5_low");
        applyStimulus(5, 10, 0, CHK_OK, 10, "h5_ok");
        applyStimulus(5, 11, 0, CHK_OK, 11, "h5_b2b");
        applyStimulus(5, 13, 0, CHK_GAP, 12, "h5_gap2");

        set_valid_i   = 1'b1;
        set_dir_i     = 1'b0;
        set_host_i    = 1;
        set_value_i   = 20;
        in_valid_i    = 1'b1;
        in_host_i     = 1;
        in_seq_i      = 20;
        #1;
        checkOutput("conf.ready", in_ready_o, 0);
        tick();
        set_valid_i = 1'b0;
        checkOutput("conf.no_result", chk_valid_o, 0);
        #1;
        checkOutput("conf.ready_after", in_ready_o, 1);
        tick();
        in_valid_i = 1'b0;
        checkOutput("conf.valid", chk_valid_o, 1);
        checkOutput("conf.status", chk_status_o, CHK_OK);
        checkOutput("conf.expected", chk_expected_o, 20);

        set_valid_i = 1'b1;
        set_dir_i   = 1'b0;
        set_host_i  = 6;
        set_value_i = 50;
        in_valid_i  = 1'b1;
        in_host_i   = 1;
        in_seq_i    = 21;
        #1;
        checkOutput("other_host.ready", in_ready_o, 1);
        tick();
        set_valid_i = 1'b0;
        in_valid_i  = 1'b0;
        checkOutput("other_host.status", chk_status_o, CHK_OK);
        checkOutput("other_host.expected", chk_expected_o, 21);
        applyStimulus(6, 50, 0, CHK_OK, 50, "h6_set");

        set_valid_i = 1'b1;
        set_dir_i   = 1'b1;
        set_host_i  = 1;
        set_value_i = 7;
        applyStimulus(1, 22, 0, CHK_OK, 22, "other_table");
        set_valid_i = 1'b0;

        requestOut(0, 1, 80'h31, 1, 0, "out_h0_first");
        setCounter(1, 0, 32'd4294967290);
        requestOut(0, 32'd4294967290, 80'h34323934393637323930, 10, 0, "out_h0_big");
        setCounter(1, 2, 32'hFFFF_FFFF);
        requestOut(2, 32'hFFFF_FFFF, 80'h34323934393637323935, 10, 1, "out_h2_wrap");
        requestOut(2, 1, 80'h31, 1, 0, "out_h2_after");
        setCounter(1, 4, 100);
        requestOut(4, 100, 80'h313030, 3, 0, "out_h4_100");
        requestOut(1, 7, 80'h37, 1, 0, "out_h1_set");

        set_valid_i = 1'b1;
        set_dir_i   = 1'b1;
        set_host_i  = 3;
        set_value_i = 40;
        out_req_i   = 1'b1;
        out_host_i  = 3;
        #1;
        checkOutput("out_conf.accept", out_accept_o, 0);
        tick();
        set_valid_i = 1'b0;
        out_req_i   = 1'b0;
        checkOutput("out_conf.state", out_valid_o, 0);
        requestOut(3, 40, 80'h3430, 2, 0, "out_h3_set");

        out_req_i  = 1'b1;
        out_host_i = 0;
        #1;
        checkOutput("rst_conv.accept", out_accept_o, 1);
        tick();
        out_req_i = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        tick();
        checkOutput("rst_conv.valid", out_valid_o, 0);
        checkOutput("rst_conv.seq", out_seq_o, 0);
        checkOutput("rst_conv.size", out_size_o, 0);
        checkOutput("rst_conv.ascii", out_ascii_o, 0);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            tick();
            if (out_valid_o) seen++;
        end
        checkOutput("rst_conv.no_valid", seen, 0);
        requestOut(0, 1, 80'h31, 1, 0, "out_after_reset");
        applyStimulus(5, 1, 0, CHK_OK, 1, "in_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fix_seq_manager.md
# fix_seq_manager

Per-host FIX sequence-number manager for the session layer. It checks inbound MsgSeqNum(34) against a per-host expected counter and classifies each message as in-order, gap, too-low or possible duplicate. It allocates outbound sequence numbers from a separate per-host counter and renders each one as ASCII digits for the message builder. It sits between the session manager and the received-message processor / outbound message assembler.

## Interface
- HOST_ADDR_WIDTH, default `HOST_ADDR_WIDTH: host index width; table depth is 2**HOST_ADDR_WIDTH.
- SEQ_WIDTH, default 32: binary sequence-number width.
- DIGITS, default 10: ASCII digit capacity. Must satisfy 10**DIGITS > 2**SEQ_WIDTH−1; checked at elaboration.
- SIZE_WIDTH, default 4: width of the digit-count output.
- clk, input, 1: single clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- in_valid_i, input, 1: inbound check request.
- in_ready_o, output, 1: check accepted when in_valid_i && in_ready_o.
- in_host_i, input, HOST_ADDR_WIDTH: inbound host index.
- in_seq_i, input, SEQ_WIDTH: received MsgSeqNum.
- in_poss_dup_i, input, 1: PossDupFlag(43)=Y.
- chk_valid_o, output, 1: one-cycle result strobe.
- chk_status_o, output, 2: 0 OK, 1 GAP, 2 LOW, 3 DUP.
- chk_expected_o, output, SEQ_WIDTH: expected value before the update.
- set_valid_i, input, 1: overwrite one counter (SequenceReset/Logon).
- set_dir_i, input, 1: 0 selects the inbound table, 1 the outbound table.
- set_host_i, input, HOST_ADDR_WIDTH: host index for the overwrite.
- set_value_i, input, SEQ_WIDTH: new counter value.
- out_req_i, input, 1: request the next outbound number.
- out_host_i, input, HOST_ADDR_WIDTH: outbound host index.
- out_accept_o, output, 1: request taken this cycle.
- out_valid_o, output, 1: result valid; held until out_ready_i.
- out_ready_i, input, 1: consumer handshake.
- out_seq_o, output, SEQ_WIDTH: allocated number, binary.
- out_ascii_o, output, 8*DIGITS: byte k is decimal digit k, where k=0 is the least significant digit; bytes at and above out_size_o read 0x00.
- out_size_o, output, SIZE_WIDTH: count of significant digits, minimum 1.
- seq_wrap_o, output, 1: pulses when any counter wraps.

## Operation
- Two flop tables, in_tbl and out_tbl, one SEQ_WIDTH entry per host, each entry with a valid bit.
  - Reset clears all valid bits.
  - An entry whose valid bit is clear reads as 1.
  - Any write sets the entry's valid bit.
- Increment rule: all-ones → 1 and seq_wrap_o pulses for one cycle; otherwise +1. Value 0 is never produced by an increment.
- Inbound check, with E = in_tbl[in_host_i]:
  - in_seq_i == E → OK; the entry becomes inc(E).
  - in_seq_i > E → GAP; no update.
  - in_seq_i < E with in_poss_dup_i=1 → DUP; otherwise LOW. No update in either case.
- Set: writes set_value_i into the selected table.
- Conflicts:
  - Set beats a same-cycle check or outbound request to the same table and host.
  - in_ready_o and out_accept_o drop combinationally for that cycle only.
  - Different hosts or different tables never conflict.
- Outbound FSM:
  - IDLE: out_accept_o = out_req_i && no conflict. On accept, capture S = out_tbl[out_host_i], write inc(S), start the converter, go to CONV.
  - CONV: wait for converter done, then go to HOLD.
  - HOLD: out_valid_o=1 with stable outputs; on out_ready_i go to IDLE.
  - out_accept_o is 0 in CONV and HOLD.
- Reset mid-operation: the FSM returns to IDLE, the converter aborts, and all tables read as 1.
- Reset values: every output is 0, and out_size_o is 0.

## Timing
- Check accepted in cycle N → chk_valid_o and result in cycle N+1; the table updates at the same edge.
- Back-to-back checks on the same host in cycles N and N+1 see the updated value with no stall.
- Set in cycle N is visible to a read in cycle N+1.
- Outbound accepted in cycle N:
  - Converter runs SEQ_WIDTH double-dabble iterations, cycles N+1 .. N+SEQ_WIDTH.
  - out_valid_o rises in cycle N+SEQ_WIDTH+1.
  - Minimum throughput is one allocation per SEQ_WIDTH+2 cycles.
- The counter increments at accept time, so a set arriving during CONV does not alter the number in flight.
- seq_wrap_o is asserted in the cycle after the wrapping write.

## Structure
- Shared package (fix_seq_pkg):
  - chk_status enum (OK/GAP/LOW/DUP).
  - Outbound FSM state enum.
  - ASCII_ZERO = 8'h30.
  - Digit-capacity check function.
- Sub-module fix_bin2ascii: iterative double-dabble.
  - Interface: start/done, SEQ_WIDTH binary in, DIGITS BCD.
  - Outputs: ASCII bytes with leading-zero suppression, plus significant-digit count.
  - Reset: rst_n.

## Test plan
- Reset, then in_host=3, seq=1 → OK, expected=1; a second check with seq=1 → LOW, expected=2.
- in_tbl[5]=10, check seq=14 → GAP, expected stays 10; check seq=7 with poss_dup=1 → DUP.
- Fresh out_req host 0 → out_seq=1, ascii byte0=0x31, size=1; set outbound host 0 to 4294967290 → ascii "4294967290", size=10, out_valid at N+33.
- Set outbound host 2 to 0xFFFFFFFF, then req → out_seq=0xFFFFFFFF and seq_wrap pulse; next req → out_seq=1.
- Same-cycle set (dir 0, host 1) and check on host 1 → in_ready_o=0; the check completes next cycle against the new value.
- rst_n low during CONV → out_valid stays 0, FSM returns to IDLE, next req host 0 returns 1.
